// File: rtl/axi4s_elastic_fifo.sv
// axi4s_elastic_fifo
//   AXI4-Stream elastic buffer built on a DEPTH-entry register file. Carries
//   tdata/tkeep/tlast/tuser. Every output is driven from registers only, so
//   there is no combinational path from the upstream (m_*) side to the
//   downstream (s_*) side, and s_tready_i never reaches m_tready_o.
//   With PACKET_MODE=1 the output is held off until a whole packet (a tlast
//   beat) is stored, or until the buffer fills with no tlast in it.
//
// Ports
//   clk_i          clock, rising edge
//   rst_ni         asynchronous active-low reset
//   m_t*_i         upstream beat (data, keep, last, user, valid)
//   m_tready_o     upstream ready, registered
//   s_t*_o         downstream beat (zeroed whenever s_tvalid_o=0)
//   s_tready_i     downstream ready
//   level_o        number of stored beats, registered
//   almost_full_o  level_o >= AFULL_LVL, registered
module axi4s_elastic_fifo #(
    parameter int AXI_WIDTH   = 64,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 4,
    parameter int PACKET_MODE = 0,
    parameter int AFULL_LVL   = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic [AXI_WIDTH-1:0]         m_tdata_i,
    input  logic [AXI_WIDTH/8-1:0]       m_tkeep_i,
    input  logic                         m_tlast_i,
    input  logic [USER_WIDTH-1:0]        m_tuser_i,
    input  logic                         m_tvalid_i,
    output logic                         m_tready_o,
    output logic [AXI_WIDTH-1:0]         s_tdata_o,
    output logic [AXI_WIDTH/8-1:0]       s_tkeep_o,
    output logic                         s_tlast_o,
    output logic [USER_WIDTH-1:0]        s_tuser_o,
    output logic                         s_tvalid_o,
    input  logic                         s_tready_i,
    output logic [$clog2(DEPTH+1)-1:0]   level_o,
    output logic                         almost_full_o
);

    localparam int KEEP_W  = AXI_WIDTH / 8;
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = USER_WIDTH + 1 + KEEP_W + AXI_WIDTH;
    localparam int LAST_B  = AXI_WIDTH + KEEP_W;

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_next;
    logic [LVL_W-1:0] last_cnt;
    logic [LVL_W-1:0] last_cnt_next;
    logic             flush_r;
    logic             flush_next;
    logic             m_tready;
    logic             almost_full;
    logic             push;
    logic             pop;
    logic             s_tvalid;
    logic             head_last;
    logic [ENTRY_W-1:0] head;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + PTR_W'(1);
    endfunction

    assign head      = mem[rd_ptr];
    assign head_last = head[LAST_B];

    // In packet mode the head is only offered once a complete packet is
    // stored, or once flush_r releases an oversize packet from a full buffer.
    assign s_tvalid = (level != '0) &
                      ((PACKET_MODE == 0) | (last_cnt != '0) | flush_r);

    // push relies on the registered ready: no push while full, even if a pop
    // happens in the same cycle, so s_tready_i stays out of m_tready_o.
    assign push = m_tvalid_i & m_tready;
    assign pop  = s_tvalid & s_tready_i;

    always_comb begin
        level_next    = level + LVL_W'(push) - LVL_W'(pop);
        last_cnt_next = last_cnt + LVL_W'(push & m_tlast_i) - LVL_W'(pop & head_last);
        flush_next    = flush_r;
        if (pop && head_last) begin
            flush_next = 1'b0;
        end else if ((level == LVL_W'(DEPTH)) && (last_cnt == '0)) begin
            flush_next = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            last_cnt    <= '0;
            flush_r     <= 1'b0;
            m_tready    <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            level       <= level_next;
            last_cnt    <= last_cnt_next;
            flush_r     <= flush_next;
            m_tready    <= (level_next != LVL_W'(DEPTH));
            almost_full <= (level_next >= LVL_W'(AFULL_LVL));
        end
    end

    // Storage is data only and carries no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {m_tuser_i, m_tlast_i, m_tkeep_i, m_tdata_i};
        end
    end

    assign m_tready_o    = m_tready;
    assign level_o       = level;
    assign almost_full_o = almost_full;
    assign s_tvalid_o    = s_tvalid;
    assign s_tdata_o     = s_tvalid ? head[AXI_WIDTH-1:0] : '0;
    assign s_tkeep_o     = s_tvalid ? head[LAST_B-1:AXI_WIDTH] : '0;
    assign s_tlast_o     = s_tvalid ? head_last : 1'b0;
    assign s_tuser_o     = s_tvalid ? head[ENTRY_W-1:LAST_B+1] : '0;

endmodule

// File: tb/tb_axi4s_elastic_fifo.sv
// Testbench for axi4s_elastic_fifo: three instances (DEPTH=4 cut-through,
// DEPTH=3 cut-through, DEPTH=8 packet mode) sharing clock and reset.
module tb_axi4s_elastic_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [0:0]  u;
    } beat_t;

    // instance A: DEPTH=4
    logic [63:0] m_tdata_a = '0;
    logic [7:0]  m_tkeep_a = '0;
    logic        m_tlast_a = 1'b0;
    logic [0:0]  m_tuser_a = '0;
    logic        m_tvalid_a = 1'b0;
    logic        m_tready_a;
    logic [63:0] s_tdata_a;
    logic [7:0]  s_tkeep_a;
    logic        s_tlast_a;
    logic [0:0]  s_tuser_a;
    logic        s_tvalid_a;
    logic        s_tready_a = 1'b0;
    logic [2:0]  level_a;
    logic        af_a;

    // instance B: DEPTH=3
    logic [63:0] m_tdata_b = '0;
    logic [7:0]  m_tkeep_b = '0;
    logic        m_tlast_b = 1'b0;
    logic [0:0]  m_tuser_b = '0;
    logic        m_tvalid_b = 1'b0;
    logic        m_tready_b;
    logic [63:0] s_tdata_b;
    logic [7:0]  s_tkeep_b;
    logic        s_tlast_b;
    logic [0:0]  s_tuser_b;
    logic        s_tvalid_b;
    logic        s_tready_b = 1'b0;
    logic [1:0]  level_b;
    logic        af_b;

    // instance C: DEPTH=8, packet mode
    logic [63:0] m_tdata_c = '0;
    logic [7:0]  m_tkeep_c = '0;
    logic        m_tlast_c = 1'b0;
    logic [0:0]  m_tuser_c = '0;
    logic        m_tvalid_c = 1'b0;
    logic        m_tready_c;
    logic [63:0] s_tdata_c;
    logic [7:0]  s_tkeep_c;
    logic        s_tlast_c;
    logic [0:0]  s_tuser_c;
    logic        s_tvalid_c;
    logic        s_tready_c = 1'b0;
    logic [3:0]  level_c;
    logic        af_c;

    axi4s_elastic_fifo #(.AXI_WIDTH(64), .USER_WIDTH(1), .DEPTH(4), .PACKET_MODE(0), .AFULL_LVL(3)) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .m_tdata_i(m_tdata_a), .m_tkeep_i(m_tkeep_a), .m_tlast_i(m_tlast_a), .m_tuser_i(m_tuser_a),
        .m_tvalid_i(m_tvalid_a), .m_tready_o(m_tready_a),
        .s_tdata_o(s_tdata_a), .s_tkeep_o(s_tkeep_a), .s_tlast_o(s_tlast_a), .s_tuser_o(s_tuser_a),
        .s_tvalid_o(s_tvalid_a), .s_tready_i(s_tready_a),
        .level_o(level_a), .almost_full_o(af_a));

    axi4s_elastic_fifo #(.AXI_WIDTH(64), .USER_WIDTH(1), .DEPTH(3), .PACKET_MODE(0), .AFULL_LVL(2)) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .m_tdata_i(m_tdata_b), .m_tkeep_i(m_tkeep_b), .m_tlast_i(m_tlast_b), .m_tuser_i(m_tuser_b),
        .m_tvalid_i(m_tvalid_b), .m_tready_o(m_tready_b),
        .s_tdata_o(s_tdata_b), .s_tkeep_o(s_tkeep_b), .s_tlast_o(s_tlast_b), .s_tuser_o(s_tuser_b),
        .s_tvalid_o(s_tvalid_b), .s_tready_i(s_tready_b),
        .level_o(level_b), .almost_full_o(af_b));

    axi4s_elastic_fifo #(.AXI_WIDTH(64), .USER_WIDTH(1), .DEPTH(8), .PACKET_MODE(1), .AFULL_LVL(6)) dut_c (
        .clk_i(clk), .rst_ni(rst_n),
        .m_tdata_i(m_tdata_c), .m_tkeep_i(m_tkeep_c), .m_tlast_i(m_tlast_c), .m_tuser_i(m_tuser_c),
        .m_tvalid_i(m_tvalid_c), .m_tready_o(m_tready_c),
        .s_tdata_o(s_tdata_c), .s_tkeep_o(s_tkeep_c), .s_tlast_o(s_tlast_c), .s_tuser_o(s_tuser_c),
        .s_tvalid_o(s_tvalid_c), .s_tready_i(s_tready_c),
        .level_o(level_c), .almost_full_o(af_c));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_tvalid_a = 1'b1;
        m_tdata_a = 64'hDEAD_BEEF;
        m_tkeep_a = 8'hFF;
        repeat (3) step();
        checks++;
        if (m_tready_a !== 1'b0 || s_tvalid_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: m_tready=%b s_tvalid=%b, required 0 0", m_tready_a, s_tvalid_a);
        end
        checks++;
        if (level_a !== 3'd0 || af_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_level: level=%0d af=%b, required 0 0", level_a, af_a);
        end
        checks++;
        if (s_tdata_a !== 64'd0 || s_tkeep_a !== 8'd0) begin
            failures++;
            $display("FAIL reset_gating: data=%h keep=%h, required 0 0", s_tdata_a, s_tkeep_a);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (m_tready_a !== 1'b1 || m_tready_b !== 1'b1 || m_tready_c !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready: a=%b b=%b c=%b, required 1 1 1", m_tready_a, m_tready_b, m_tready_c);
        end
        checks++;
        if (level_a !== 3'd0 || s_tvalid_a !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_nopush: level=%0d s_tvalid=%b, required 0 0", level_a, s_tvalid_a);
        end
        m_tvalid_a = 1'b0;
        step();
    endtask

    task automatic test_streaming();
        s_tready_a = 1'b1;
        for (int i = 0; i < 32; i++) begin
            m_tvalid_a = 1'b1;
            m_tdata_a = 64'(i);
            m_tkeep_a = 8'(i) ^ 8'hFF;
            m_tlast_a = (i % 8 == 7);
            m_tuser_a = 1'(i);
            step();
            checks++;
            if (s_tvalid_a !== 1'b1 || s_tdata_a !== 64'(i) || s_tkeep_a !== (8'(i) ^ 8'hFF) ||
                s_tlast_a !== (i % 8 == 7) || s_tuser_a !== 1'(i) || level_a !== 3'd1 || m_tready_a !== 1'b1) begin
                failures++;
                $display("FAIL stream_beat%0d: valid=%b data=%0d keep=%h last=%b user=%b level=%0d ready=%b, required 1 %0d %h %b %b 1 1",
                         i, s_tvalid_a, s_tdata_a, s_tkeep_a, s_tlast_a, s_tuser_a, level_a, m_tready_a,
                         i, 8'(i) ^ 8'hFF, (i % 8 == 7), 1'(i));
            end
        end
        m_tvalid_a = 1'b0;
        m_tlast_a = 1'b0;
        step();
        checks++;
        if (s_tvalid_a !== 1'b0 || level_a !== 3'd0) begin
            failures++;
            $display("FAIL stream_end: valid=%b level=%0d, required 0 0", s_tvalid_a, level_a);
        end
        s_tready_a = 1'b0;
    endtask

    task automatic test_fill_drain();
        int mv[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        int md[12] = '{100, 101, 102, 103, 104, 104, 104, 104, 105, 0, 0, 0};
        int sr[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        int el[12] = '{1, 2, 3, 4, 4, 4, 3, 3, 3, 2, 1, 0};
        int ea[12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
        int em[12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
        int ev[12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        int ed[12] = '{100, 100, 100, 100, 100, 100, 101, 102, 103, 104, 105, 0};
        m_tkeep_a = 8'hFF;
        m_tuser_a = 1'b0;
        m_tlast_a = 1'b0;
        for (int c = 0; c < 12; c++) begin
            m_tvalid_a = 1'(mv[c]);
            m_tdata_a = 64'(md[c]);
            s_tready_a = 1'(sr[c]);
            step();
            checks++;
            if (level_a !== 3'(el[c]) || af_a !== 1'(ea[c]) || m_tready_a !== 1'(em[c]) ||
                s_tvalid_a !== 1'(ev[c]) || s_tdata_a !== 64'(ed[c])) begin
                failures++;
                $display("FAIL fill_drain_cyc%0d: level=%0d af=%b ready=%b valid=%b data=%0d, required %0d %0d %0d %0d %0d",
                         c, level_a, af_a, m_tready_a, s_tvalid_a, s_tdata_a, el[c], ea[c], em[c], ev[c], ed[c]);
            end
        end
        s_tready_a = 1'b0;
    endtask

    task automatic test_random_backpressure();
        beat_t q[$];
        beat_t cur;
        beat_t exp_b;
        beat_t prev;
        logic held = 1'b0;
        logic stall = 1'b0;
        logic push;
        logic pop;
        int sent = 0;
        int popped = 0;
        int cyc = 0;
        cur = '0;
        prev = '0;
        while (popped < 1000 && cyc < 20000) begin
            if (stall) begin
                checks++;
                if (s_tvalid_b !== 1'b1 || {s_tdata_b, s_tkeep_b, s_tlast_b, s_tuser_b} !== prev) begin
                    failures++;
                    $display("FAIL rand_stable_cyc%0d: valid=%b beat=%h, required 1 %h",
                             cyc, s_tvalid_b, {s_tdata_b, s_tkeep_b, s_tlast_b, s_tuser_b}, prev);
                end
            end
            checks++;
            if (32'(level_b) != q.size()) begin
                failures++;
                $display("FAIL rand_level_cyc%0d: level=%0d, required %0d", cyc, level_b, q.size());
            end
            if (!held) begin
                m_tvalid_b = (sent < 1000) && ($urandom_range(0, 1) == 1);
                cur.d = {$urandom, $urandom};
                cur.k = 8'($urandom);
                cur.l = 1'($urandom);
                cur.u = 1'($urandom);
                m_tdata_b = cur.d;
                m_tkeep_b = cur.k;
                m_tlast_b = cur.l;
                m_tuser_b = cur.u;
            end
            s_tready_b = ($urandom_range(0, 1) == 1);
            push = m_tvalid_b & m_tready_b;
            pop = s_tvalid_b & s_tready_b;
            if (pop) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL rand_pop_empty_cyc%0d: valid=%b, required 0", cyc, s_tvalid_b);
                end else begin
                    exp_b = q.pop_front();
                    if ({s_tdata_b, s_tkeep_b, s_tlast_b, s_tuser_b} !== exp_b) begin
                        failures++;
                        $display("FAIL rand_beat%0d: beat=%h, required %h",
                                 popped, {s_tdata_b, s_tkeep_b, s_tlast_b, s_tuser_b}, exp_b);
                    end
                end
                popped++;
            end
            if (push) begin
                q.push_back(cur);
                sent++;
            end
            held = m_tvalid_b & ~push;
            stall = s_tvalid_b & ~s_tready_b;
            prev = {s_tdata_b, s_tkeep_b, s_tlast_b, s_tuser_b};
            step();
            cyc++;
        end
        checks++;
        if (popped < 1000) begin
            failures++;
            $display("FAIL rand_timeout: popped=%0d, required 1000", popped);
        end
        m_tvalid_b = 1'b0;
        s_tready_b = 1'b0;
    endtask

    task automatic test_packet_mode();
        int idx_in;
        int idx_out;
        int cyc;
        m_tkeep_c = 8'hFF;
        m_tuser_c = 1'b0;
        s_tready_c = 1'b0;
        // 3-beat packet
        for (int i = 0; i < 3; i++) begin
            m_tvalid_c = 1'b1;
            m_tdata_c = 64'(200 + i);
            m_tlast_c = (i == 2);
            step();
            checks++;
            if (s_tvalid_c !== (i == 2) || level_c !== 4'(i + 1)) begin
                failures++;
                $display("FAIL pkt3_hold%0d: valid=%b level=%0d, required %b %0d", i, s_tvalid_c, level_c, (i == 2), i + 1);
            end
        end
        m_tvalid_c = 1'b0;
        m_tlast_c = 1'b0;
        s_tready_c = 1'b1;
        checks++;
        if (s_tdata_c !== 64'd200 || s_tlast_c !== 1'b0) begin
            failures++;
            $display("FAIL pkt3_head: data=%0d last=%b, required 200 0", s_tdata_c, s_tlast_c);
        end
        step();
        step();
        checks++;
        if (s_tvalid_c !== 1'b1 || s_tdata_c !== 64'd202 || s_tlast_c !== 1'b1) begin
            failures++;
            $display("FAIL pkt3_tail: valid=%b data=%0d last=%b, required 1 202 1", s_tvalid_c, s_tdata_c, s_tlast_c);
        end
        step();
        checks++;
        if (s_tvalid_c !== 1'b0 || level_c !== 4'd0) begin
            failures++;
            $display("FAIL pkt3_done: valid=%b level=%0d, required 0 0", s_tvalid_c, level_c);
        end
        // 12-beat oversize packet
        s_tready_c = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_tvalid_c = 1'b1;
            m_tdata_c = 64'(300 + i);
            m_tlast_c = 1'b0;
            step();
            checks++;
            if (s_tvalid_c !== 1'b0) begin
                failures++;
                $display("FAIL pkt12_hold%0d: valid=%b, required 0", i, s_tvalid_c);
            end
        end
        checks++;
        if (level_c !== 4'd8 || m_tready_c !== 1'b0) begin
            failures++;
            $display("FAIL pkt12_full: level=%0d ready=%b, required 8 0", level_c, m_tready_c);
        end
        m_tdata_c = 64'd308;
        step();
        checks++;
        if (s_tvalid_c !== 1'b1 || s_tdata_c !== 64'd300 || level_c !== 4'd8) begin
            failures++;
            $display("FAIL pkt12_flush: valid=%b data=%0d level=%0d, required 1 300 8", s_tvalid_c, s_tdata_c, level_c);
        end
        idx_in = 8;
        idx_out = 0;
        cyc = 0;
        s_tready_c = 1'b1;
        while (idx_out < 12 && cyc < 100) begin
            m_tvalid_c = (idx_in < 12);
            m_tdata_c = 64'(300 + idx_in);
            m_tlast_c = (idx_in == 11);
            if (s_tvalid_c & s_tready_c) begin
                checks++;
                if (s_tdata_c !== 64'(300 + idx_out) || s_tlast_c !== (idx_out == 11)) begin
                    failures++;
                    $display("FAIL pkt12_beat%0d: data=%0d last=%b, required %0d %b",
                             idx_out, s_tdata_c, s_tlast_c, 300 + idx_out, (idx_out == 11));
                end
                idx_out++;
            end
            if (m_tvalid_c & m_tready_c) begin
                idx_in++;
            end
            step();
            cyc++;
        end
        m_tvalid_c = 1'b0;
        m_tlast_c = 1'b0;
        checks++;
        if (idx_out != 12 || s_tvalid_c !== 1'b0 || level_c !== 4'd0) begin
            failures++;
            $display("FAIL pkt12_complete: popped=%0d valid=%b level=%0d, required 12 0 0", idx_out, s_tvalid_c, level_c);
        end
        s_tready_c = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        s_tready_a = 1'b0;
        m_tkeep_a = 8'hFF;
        m_tlast_a = 1'b0;
        m_tvalid_a = 1'b1;
        m_tdata_a = 64'd400;
        step();
        m_tdata_a = 64'd401;
        step();
        m_tvalid_a = 1'b0;
        checks++;
        if (level_a !== 3'd2 || s_tvalid_a !== 1'b1) begin
            failures++;
            $display("FAIL midrst_pre: level=%0d valid=%b, required 2 1", level_a, s_tvalid_a);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (s_tvalid_a !== 1'b0 || level_a !== 3'd0 || m_tready_a !== 1'b0 || s_tdata_a !== 64'd0) begin
            failures++;
            $display("FAIL midrst_async: valid=%b level=%0d ready=%b data=%0d, required 0 0 0 0",
                     s_tvalid_a, level_a, m_tready_a, s_tdata_a);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step();
        checks++;
        if (m_tready_a !== 1'b1 || level_a !== 3'd0) begin
            failures++;
            $display("FAIL midrst_release: ready=%b level=%0d, required 1 0", m_tready_a, level_a);
        end
        s_tready_a = 1'b1;
        m_tvalid_a = 1'b1;
        m_tdata_a = 64'd500;
        step();
        checks++;
        if (s_tvalid_a !== 1'b1 || s_tdata_a !== 64'd500 || s_tlast_a !== 1'b0) begin
            failures++;
            $display("FAIL midrst_beat0: valid=%b data=%0d last=%b, required 1 500 0", s_tvalid_a, s_tdata_a, s_tlast_a);
        end
        m_tdata_a = 64'd501;
        m_tlast_a = 1'b1;
        step();
        m_tvalid_a = 1'b0;
        m_tlast_a = 1'b0;
        checks++;
        if (s_tvalid_a !== 1'b1 || s_tdata_a !== 64'd501 || s_tlast_a !== 1'b1) begin
            failures++;
            $display("FAIL midrst_beat1: valid=%b data=%0d last=%b, required 1 501 1", s_tvalid_a, s_tdata_a, s_tlast_a);
        end
        step();
        checks++;
        if (s_tvalid_a !== 1'b0 || level_a !== 3'd0) begin
            failures++;
            $display("FAIL midrst_done: valid=%b level=%0d, required 0 0", s_tvalid_a, level_a);
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_drain();
        test_random_backpressure();
        test_packet_mode();
        test_reset_mid_packet();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
